// File: rtl/led_pkg.sv
// Shared constants for the LED sequencer: pattern modes, FSM states, bounce direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Frame-rate prescaler: counts 0..DIV-1 while enabled, strobes tick on the last count.
module led_prescaler #(
    parameter int DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // A clear (restart) suppresses the strobe so the new sequence begins a full frame.
    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: start/stop FSM, per-tick frame engine, optional PWM dimming.
// Define LED_PWM_EN to add the bright port and the free-running PWM counter.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int N_LED = 4,
    parameter int DIV   = 12_500_000,
    parameter int PWM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [N_LED-1:0] pattern,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0] bright,
`endif
    output logic             busy,
    output logic             tick,
    output logic [N_LED-1:0] led
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    dir_e               dir_q, dir_d;
    logic [N_LED-1:0]   pat_q, pat_d;
    logic [N_LED-1:0]   frame_q, frame_d;
    logic               tick_q;
    logic               pre_tick;

    led_prescaler #(.DIV(DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start | stop | (state_q == ST_IDLE)),
        .en    (state_q == ST_RUN),
        .tick  (pre_tick)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        frame_d = frame_q;
        dir_d   = dir_q;
        if (stop) begin
            state_d = ST_IDLE;
            frame_d = '0;
            dir_d   = DIR_LEFT;
        end else if (start) begin
            state_d = ST_RUN;
            mode_d  = mode_e'(mode);
            pat_d   = pattern;
            dir_d   = DIR_LEFT;
            frame_d = (mode_e'(mode) == MODE_BOUNCE) ? N_LED'(1) : pattern;
        end else if (pre_tick) begin
            case (mode_q)
                MODE_BLINK:  frame_d = (frame_q == pat_q) ? '0 : pat_q;
                MODE_ROTATE: frame_d = {frame_q[N_LED-2:0], frame_q[N_LED-1]};
                MODE_BOUNCE: begin
                    // Reverse on reaching either end; the end bit is shown for exactly one frame.
                    if (dir_q == DIR_LEFT) begin
                        if (frame_q[N_LED-1]) begin
                            dir_d   = DIR_RIGHT;
                            frame_d = frame_q >> 1;
                        end else begin
                            frame_d = frame_q << 1;
                        end
                    end else begin
                        if (frame_q[0]) begin
                            dir_d   = DIR_LEFT;
                            frame_d = frame_q << 1;
                        end else begin
                            frame_d = frame_q >> 1;
                        end
                    end
                end
                default:     frame_d = frame_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_STATIC;
            pat_q   <= '0;
            frame_q <= '0;
            dir_q   <= DIR_LEFT;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            frame_q <= frame_d;
            dir_q   <= dir_d;
            tick_q  <= pre_tick;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign tick = tick_q;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] p_q;
    logic [N_LED-1:0] led_q;

    // Gate the next frame so LED latency from start matches the undimmed build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            led_q <= '0;
        end else begin
            p_q   <= p_q + 1'b1;
            led_q <= frame_d & {N_LED{p_q < bright}};
        end
    end

    assign led = led_q;
`else
    assign led = frame_q;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed vector table, async reset checks, PWM duty, random vs model.
module tb_led_seq_ctrl;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop;
    logic [1:0]    mode;
    logic [N-1:0]  pattern;
    logic          busy, tick;
    logic [N-1:0]  led;
`ifdef LED_PWM_EN
    logic [PW-1:0] bright;
`endif

    always #5 clk = ~clk;

    led_seq_ctrl #(.N_LED(N), .DIV(D), .PWM_W(PW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .pattern (pattern),
`ifdef LED_PWM_EN
        .bright  (bright),
`endif
        .busy    (busy),
        .tick    (tick),
        .led     (led)
    );

    typedef struct {
        bit         st;
        bit         sp;
        logic [1:0] md;
        logic [3:0] pt;
        int         n;
        logic [3:0] el;
        bit         eb;
        bit         et;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: run flag, latched mode/pattern, edges since start, PWM phase
    bit         m_run;
    logic [1:0] m_mode;
    logic [3:0] m_pat;
    int         m_c;
    int         pw;
    bit         m_lit;

    function automatic logic [3:0] ref_frame(logic [1:0] md, logic [3:0] pt, int n);
        logic [7:0] w;
        int p, b;
        case (md)
            2'd0: return pt;
            2'd1: return (n % 2) ? 4'b0000 : pt;
            2'd2: begin
                w = {4'b0000, pt} << (n % N);
                return w[3:0] | w[7:4];
            end
            default: begin
                p = n % (2 * (N - 1));
                b = (p < N) ? p : 2 * (N - 1) - p;
                return 4'(1 << b);
            end
        endcase
    endfunction

    function automatic void add(bit st, bit sp, logic [1:0] md, logic [3:0] pt, int n,
                                logic [3:0] el, bit eb, bit et);
        vec_t v;
        v.st = st; v.sp = sp; v.md = md; v.pt = pt; v.n = n;
        v.el = el; v.eb = eb; v.et = et;
        tbl.push_back(v);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check(input string nm, input logic [3:0] el, input bit eb, input bit et);
        logic [3:0] m;
        m = m_lit ? el : 4'b0000;
        cmp({nm, ".led"},  32'(led),  32'(m));
        cmp({nm, ".busy"}, 32'(busy), 32'(eb));
        cmp({nm, ".tick"}, 32'(tick), 32'(et));
    endtask

    task automatic check_model(input string nm);
        int n;
        if (m_run) begin
            n = (m_c - 1) / D;
            check(nm, ref_frame(m_mode, m_pat, n), 1'b1, (m_c > 1) && ((m_c - 1) % D == 0));
        end else begin
            check(nm, 4'b0000, 1'b0, 1'b0);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_c = 0; pw = 0; m_lit = 1;
    endtask

    // Called just after a rising edge: drive inputs, take one edge, update the model.
    task automatic step(input bit st, input bit sp, input logic [1:0] md, input logic [3:0] pt);
        start = st; stop = sp; mode = md; pattern = pt;
`ifdef LED_PWM_EN
        m_lit = (pw < int'(bright));
        pw    = (pw + 1) % (1 << PW);
`else
        m_lit = 1;
`endif
        @(posedge clk);
        if (sp) begin
            m_run = 0;
        end else if (st) begin
            m_run = 1; m_mode = md; m_pat = pt; m_c = 1;
        end else if (m_run) begin
            m_c++;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; mode = 2'd2; pattern = 4'b1111;
`ifdef LED_PWM_EN
        bright = '1;
`endif
        model_reset();

        // Reset held with start asserted
        repeat (3) @(posedge clk);
        #1;
        check("reset", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1; start = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2'($urandom), 4'($urandom));
            check("idle_after_reset", 4'b0000, 1'b0, 1'b0);
        end

        // ROTATE 0001
        add(1, 0, 2'd2, 4'b0001, 1, 4'b0001, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 3, 4'b0001, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 1, 4'b0010, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0100, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b1000, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0001, 1, 1);
        // BOUNCE (restart while running)
        add(1, 0, 2'd3, 4'b0110, 1, 4'b0001, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0010, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0100, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b1000, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0100, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0010, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0001, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0010, 1, 1);
        // BLINK 1010, stop mid-frame
        add(1, 0, 2'd1, 4'b1010, 1, 4'b1010, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0000, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b1010, 1, 1);
        add(0, 0, 2'd0, 4'b0000, 2, 4'b1010, 1, 0);
        add(0, 1, 2'd0, 4'b0000, 1, 4'b0000, 0, 0);
        add(0, 0, 2'd0, 4'b0000, 8, 4'b0000, 0, 0);
        // start+stop together, start mid-frame clears the prescaler
        add(1, 0, 2'd0, 4'b0110, 1, 4'b0110, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 2, 4'b0110, 1, 0);
        add(1, 1, 2'd2, 4'b1111, 1, 4'b0000, 0, 0);
        add(1, 0, 2'd2, 4'b0011, 1, 4'b0011, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 3, 4'b0011, 1, 0);
        add(1, 0, 2'd2, 4'b1001, 1, 4'b1001, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 3, 4'b1001, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 1, 4'b0011, 1, 1);
        // zero pattern: dark but running and ticking
        add(1, 0, 2'd2, 4'b0000, 1, 4'b0000, 1, 0);
        add(0, 0, 2'd0, 4'b0000, 4, 4'b0000, 1, 1);
        add(1, 0, 2'd1, 4'b0000, 5, 4'b0000, 1, 1);

        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r].st, tbl[r].sp, tbl[r].md, tbl[r].pt);
            for (int j = 1; j < tbl[r].n; j++)
                step(0, 0, 2'($urandom), 4'($urandom));
            check($sformatf("vec%0d", r), tbl[r].el, tbl[r].eb, tbl[r].et);
        end

        // Asynchronous reset mid-RUN
        step(1, 0, 2'd2, 4'b1111);
        step(0, 0, 2'd0, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        m_lit = 1;
        check("async_reset", 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

`ifdef LED_PWM_EN
        begin
            int lit[N];
            bright = 4'd4;
            step(1, 0, 2'd0, 4'b1111);
            for (int i = 0; i < N; i++) lit[i] = 0;
            for (int k = 0; k < 32; k++) begin
                step(0, 0, 2'($urandom), 4'($urandom));
                check_model("pwm4");
                for (int i = 0; i < N; i++) lit[i] += int'(led[i]);
            end
            for (int i = 0; i < N; i++) cmp($sformatf("pwm4_duty%0d", i), 32'(lit[i]), 32'd8);
            bright = 4'd0;
            for (int i = 0; i < N; i++) lit[i] = 0;
            for (int k = 0; k < 16; k++) begin
                step(0, 0, 2'($urandom), 4'($urandom));
                for (int i = 0; i < N; i++) lit[i] += int'(led[i]);
            end
            for (int i = 0; i < N; i++) cmp($sformatf("pwm0_duty%0d", i), 32'(lit[i]), 32'd0);
        end
`endif

        // Random stimulus against the model
        for (int k = 0; k < 800; k++) begin
`ifdef LED_PWM_EN
            bright = 4'($urandom);
`endif
            step(($urandom % 8) == 0, ($urandom % 16) == 0, 2'($urandom), 4'($urandom));
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
